// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared types and constants for the host-side memory sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    WAIT_RDY  = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DATA = 3'd3,
    ERR       = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_lat_cnt.sv
// ---------------------------------------------------------------------------
// mem_lat_cnt : clearable up-counter with equality compare against cmp_i
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lat_cnt
  import mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] cmp_i,
  output logic         eq_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_o = (cnt_q == cmp_i);

endmodule

`default_nettype wire

// File: rtl/mem_host_seq.sv
// ---------------------------------------------------------------------------
// mem_host_seq : waits for memory readiness, then issues single accesses
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_host_seq
  import mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic          pulse,
  input  logic          rst,
  input  logic          mem_ready,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic          init_err
);

  localparam logic [CNT_W-1:0] TO_CMP  = CNT_W'(TIMEOUT);
  // Latency counter is 0 on the ISSUE edge (accept + 1), so compare one lower.
  localparam logic [CNT_W-1:0] LAT_CMP = CNT_W'(RD_LAT - 1);

  state_t        state_q;
  logic          req_ready_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          init_done_q;
  logic          init_err_q;

  logic to_clr, to_inc, to_eq;
  logic lat_clr, lat_inc, lat_eq;

  assign to_clr  = (state_q != WAIT_RDY);
  assign to_inc  = (state_q == WAIT_RDY) && !mem_ready && !to_eq;
  assign lat_clr = (state_q == IDLE);
  assign lat_inc = (state_q == ISSUE) || (state_q == WAIT_DATA);

  mem_lat_cnt #(.W(CNT_W)) u_to_cnt (
    .clk   (pulse),
    .rst_n (rst),
    .clr_i (to_clr),
    .inc_i (to_inc),
    .cmp_i (TO_CMP),
    .eq_o  (to_eq)
  );

  mem_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk   (pulse),
    .rst_n (rst),
    .clr_i (lat_clr),
    .inc_i (lat_inc),
    .cmp_i (LAT_CMP),
    .eq_o  (lat_eq)
  );

  always_ff @(posedge pulse or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_RDY;
      req_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        WAIT_RDY: begin
          if (mem_ready) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
          end else if (to_eq) begin
            state_q    <= ERR;
            init_err_q <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= ISSUE;
            req_ready_q <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
          end else if (!mem_ready) begin
            state_q     <= WAIT_RDY;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (mem_we_q) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else if (lat_eq) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= mem_rdata;
          end else begin
            state_q <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (lat_eq) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= mem_rdata;
          end
        end
        ERR: begin
          req_ready_q <= 1'b0;
          init_done_q <= 1'b0;
          init_err_q  <= 1'b1;
        end
        default: begin
          state_q <= WAIT_RDY;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign init_err  = init_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_host_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_host_seq : three sequencers (RD_LAT 2/1/7) on shared stimulus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_host_seq;

  localparam int TIMEOUT = 15;

  logic       pulse = 1'b0;
  logic       rst   = 1'b0;
  logic       mem_ready = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we    = 1'b0;
  logic [7:0] req_addr  = '0;
  logic [7:0] req_wdata = '0;
  logic [7:0] mem_rdata = '0;

  logic       d_rr   [3];
  logic       d_en   [3];
  logic       d_we   [3];
  logic [7:0] d_addr [3];
  logic [7:0] d_wd   [3];
  logic       d_rv   [3];
  logic [7:0] d_rd   [3];
  logic       d_done [3];
  logic       d_err  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pulse = ~pulse;

  mem_host_seq #(.AW(8), .DW(8), .RD_LAT(2), .TIMEOUT(TIMEOUT)) u_lat2 (
    .pulse(pulse), .rst(rst), .mem_ready(mem_ready), .req_valid(req_valid),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(d_rr[0]), .mem_en(d_en[0]), .mem_we(d_we[0]), .mem_addr(d_addr[0]),
    .mem_wdata(d_wd[0]), .mem_rdata(mem_rdata), .rsp_valid(d_rv[0]),
    .rsp_rdata(d_rd[0]), .init_done(d_done[0]), .init_err(d_err[0]));

  mem_host_seq #(.AW(8), .DW(8), .RD_LAT(1), .TIMEOUT(TIMEOUT)) u_lat1 (
    .pulse(pulse), .rst(rst), .mem_ready(mem_ready), .req_valid(req_valid),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(d_rr[1]), .mem_en(d_en[1]), .mem_we(d_we[1]), .mem_addr(d_addr[1]),
    .mem_wdata(d_wd[1]), .mem_rdata(mem_rdata), .rsp_valid(d_rv[1]),
    .rsp_rdata(d_rd[1]), .init_done(d_done[1]), .init_err(d_err[1]));

  mem_host_seq #(.AW(8), .DW(8), .RD_LAT(7), .TIMEOUT(TIMEOUT)) u_lat7 (
    .pulse(pulse), .rst(rst), .mem_ready(mem_ready), .req_valid(req_valid),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(d_rr[2]), .mem_en(d_en[2]), .mem_we(d_we[2]), .mem_addr(d_addr[2]),
    .mem_wdata(d_wd[2]), .mem_rdata(mem_rdata), .rsp_valid(d_rv[2]),
    .rsp_rdata(d_rd[2]), .init_done(d_done[2]), .init_err(d_err[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 7);
  endfunction

  // Reference model: mode 0 = waiting for readiness, 1 = operational, 2 = failed.
  // An accepted access completes a fixed number of edges after acceptance.
  int         m_mode [3];
  int         m_wait [3];
  bit         m_busy [3];
  int         m_age  [3];
  bit         e_rr   [3];
  bit         e_en   [3];
  bit         e_we   [3];
  logic [7:0] e_addr [3];
  logic [7:0] e_wd   [3];
  bit         e_rv   [3];
  logic [7:0] e_rd   [3];
  bit         e_done [3];
  bit         e_err  [3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_mode[d] = 0; m_wait[d] = 0; m_busy[d] = 0; m_age[d] = 0;
      e_rr[d] = 0; e_en[d] = 0; e_we[d] = 0; e_addr[d] = '0; e_wd[d] = '0;
      e_rv[d] = 0; e_rd[d] = '0; e_done[d] = 0; e_err[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      e_en[d] = 0;
      e_rv[d] = 0;
      if (m_mode[d] == 0) begin
        if (mem_ready) begin
          m_mode[d] = 1; e_done[d] = 1; e_rr[d] = 1;
        end else if (m_wait[d] == TIMEOUT) begin
          m_mode[d] = 2; e_err[d] = 1;
        end else begin
          m_wait[d]++;
        end
      end else if (m_mode[d] == 1) begin
        if (!m_busy[d]) begin
          if (req_valid) begin
            m_busy[d] = 1; m_age[d] = 0; e_rr[d] = 0; e_en[d] = 1;
            e_we[d] = req_we; e_addr[d] = req_addr; e_wd[d] = req_wdata;
          end else if (!mem_ready) begin
            m_mode[d] = 0; m_wait[d] = 0; e_done[d] = 0; e_rr[d] = 0;
          end
        end else begin
          m_age[d]++;
          if (m_age[d] == (e_we[d] ? 1 : lat_of(d))) begin
            m_busy[d] = 0; e_rv[d] = 1; e_rr[d] = 1;
            e_rd[d] = e_we[d] ? 8'h00 : mem_rdata;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [21:0] act, exp;
    for (int d = 0; d < 3; d++) begin
      act = {d_rr[d], d_en[d], d_we[d], d_addr[d], d_wd[d], d_rv[d], d_done[d], d_err[d]};
      exp = {e_rr[d], e_en[d], e_we[d], e_addr[d], e_wd[d], e_rv[d], e_done[d], e_err[d]};
      n_tests++;
      if (act !== exp || (e_rv[d] && d_rd[d] !== e_rd[d])) begin
        n_fail++;
        $display("FAIL %s dut%0d: got {rr,en,we,addr,wd,rv,done,err}=%h rdata=%h, expected %h rdata=%h",
                 tag, d, act, d_rd[d], exp, e_rd[d]);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge pulse);
    if (rst) model_step();
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];
  int   got  [3];
  int   nrsp [3];

  initial begin
    vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h34, 8'h77, 8'h5C, 8'h5C};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    vecs[4] = '{1'b0, 8'h80, 8'h11, 8'h01, 8'h01};
    vecs[5] = '{1'b1, 8'h7E, 8'h5A, 8'hC3, 8'h00};

    model_reset();
    repeat (3) @(posedge pulse);
    #1;
    check_all("reset_state");

    // Ready arrives at edge 6 after release.
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) tick("wait_ready");
    for (int d = 0; d < 3; d++) chk("init_done_before_edge6", d_done[d], 0);
    mem_ready = 1'b1;
    tick("ready_edge6");
    for (int d = 0; d < 3; d++) begin
      chk("init_done_edge6", d_done[d], 1);
      chk("req_ready_edge6", d_rr[d], 1);
      chk("init_err_edge6", d_err[d], 0);
    end

    // Single transactions from the table; response latency measured per DUT.
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = vecs[i].we; req_addr = vecs[i].addr;
      req_wdata = vecs[i].wdata; mem_rdata = vecs[i].rdata;
      tick("vec_accept");
      req_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        chk("vec_mem_en", d_en[d], 1);
        chk("vec_mem_we", d_we[d], int'(vecs[i].we));
        chk("vec_mem_addr", d_addr[d], int'(vecs[i].addr));
        chk("vec_mem_wdata", d_wd[d], int'(vecs[i].wdata));
        got[d] = -1;
      end
      for (int e = 1; e <= 9; e++) begin
        tick("vec_wait");
        for (int d = 0; d < 3; d++) begin
          if (d_rv[d] && got[d] < 0) begin
            got[d] = e;
            chk("vec_rsp_rdata", d_rd[d], int'(vecs[i].exp_rdata));
          end
        end
      end
      for (int d = 0; d < 3; d++)
        chk("vec_rsp_latency", got[d], vecs[i].we ? 1 : lat_of(d));
    end

    // Requests held back to back, including accepts alongside rsp_valid.
    req_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      req_we = ($urandom_range(0, 3) != 0); req_addr = 8'($urandom);
      req_wdata = 8'($urandom); mem_rdata = 8'($urandom);
      tick("back_to_back");
    end
    req_valid = 1'b0;
    repeat (9) tick("drain");

    // Readiness lost while a read is in flight.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h34; mem_rdata = 8'h5C;
    tick("drop_accept");
    req_valid = 1'b0;
    tick("drop_issue");
    mem_ready = 1'b0;
    for (int d = 0; d < 3; d++) nrsp[d] = 0;
    for (int e = 0; e < 9; e++) begin
      tick("drop_wait");
      for (int d = 0; d < 3; d++) if (d_rv[d]) nrsp[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      chk("drop_read_completed", nrsp[d], (d == 1) ? 0 : 1);
      chk("drop_init_done_low", d_done[d], 0);
    end
    mem_ready = 1'b1;
    tick("regain_ready");
    for (int d = 0; d < 3; d++) chk("regain_init_done", d_done[d], 1);

    // Reset one cycle after a read is accepted.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h55;
    tick("abort_accept");
    req_valid = 1'b0;
    tick("abort_issue");
    rst = 1'b0;
    model_reset();
    #1;
    check_all("abort_immediate");
    for (int d = 0; d < 3; d++) chk("abort_no_rsp", d_rv[d], 0);
    repeat (3) tick("abort_held");

    // Readiness never arrives: error at edge TIMEOUT+1 and stays.
    mem_ready = 1'b0;
    rst = 1'b1;
    for (int e = 1; e <= TIMEOUT; e++) tick("timeout_wait");
    for (int d = 0; d < 3; d++) chk("init_err_before_timeout", d_err[d], 0);
    tick("timeout_edge");
    for (int d = 0; d < 3; d++) chk("init_err_at_timeout", d_err[d], 1);
    mem_ready = 1'b1; req_valid = 1'b1;
    repeat (4) tick("err_sticky");
    for (int d = 0; d < 3; d++) begin
      chk("err_sticky_flag", d_err[d], 1);
      chk("err_req_ready", d_rr[d], 0);
    end
    req_valid = 1'b0;

    // Randomized traffic against the model.
    @(posedge pulse); #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rand_reset");
    @(posedge pulse); #1;
    rst = 1'b1;
    for (int i = 0; i < 800; i++) begin
      mem_ready = ($urandom_range(0, 9) != 0);
      req_valid = $urandom_range(0, 1) != 0;
      req_we    = $urandom_range(0, 1) != 0;
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      mem_rdata = 8'($urandom);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
